// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus the debounced key event seen by the consumer.
interface keypad_scanner_if;
   logic [3:0] key_col;
   logic [3:0] key_row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   modport master (input key_col, output key_row, key_code, key_valid, key_held);
   modport slave  (output key_col, input key_row, key_code, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix row scanner with full-scan debounce and single-cycle key events.
module keypad_scanner #(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input logic               clk,
   input logic               rst_n,
   keypad_scanner_if.master  kp
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS);
   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] DB_PRESS   = 2'd1;
   localparam logic [1:0] PRESSED    = 2'd2;
   localparam logic [1:0] DB_RELEASE = 2'd3;

   logic [3:0]    sync1_q, sync2_q;
   logic [DW-1:0] div_q, div_d;
   logic [1:0]    row_q, row_d;
   logic [15:0]   snap_q, snap_d;
   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [3:0]    cand_q, cand_d, code_q, code_d, scan_code;
   logic          valid_q, valid_d, held_q, held_d;
   logic          tc, eval, single, match, same;
   logic [4:0]    ones;

   assign tc      = div_q == DIV_LAST;
   assign eval    = tc && row_q == 2'd3;
   assign div_d   = tc ? '0 : div_q + DW'(1);
   assign row_d   = tc ? row_q + 2'd1 : row_q;
   assign cnt_inc = cnt_q + CW'(1);
   assign single  = ones == 5'd1;
   assign match   = single && scan_code == code_q;
   assign same    = single && scan_code == cand_q;

   // The evaluating scan includes the row-3 sample taken on this very cycle.
   always_comb begin
      snap_d = snap_q;
      if (tc)
         for (int c = 0; c < 4; c++)
            snap_d[{row_q, 2'(c)}] = ~sync2_q[c];
   end

   always_comb begin
      ones      = '0;
      scan_code = '0;
      for (int i = 0; i < 16; i++)
         if (snap_d[i]) begin
            ones      = ones + 5'd1;
            scan_code = 4'(i);
         end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      code_d  = code_q;
      held_d  = held_q;
      valid_d = 1'b0;
      if (eval)
         case (state_q)
            IDLE:
               if (single) begin
                  cand_d = scan_code;
                  cnt_d  = CW'(1);
                  if (DEBOUNCE_SCANS == 1) begin
                     state_d = PRESSED;
                     code_d  = scan_code;
                     valid_d = 1'b1;
                     held_d  = 1'b1;
                  end else
                     state_d = DB_PRESS;
               end
            DB_PRESS:
               if (same) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_LAST) begin
                     state_d = PRESSED;
                     code_d  = cand_q;
                     valid_d = 1'b1;
                     held_d  = 1'b1;
                  end
               end else if (single) begin
                  cand_d = scan_code;
                  cnt_d  = CW'(1);
               end else
                  state_d = IDLE;
            PRESSED:
               if (!match) begin
                  cnt_d   = CW'(1);
                  state_d = DEBOUNCE_SCANS == 1 ? IDLE : DB_RELEASE;
                  held_d  = DEBOUNCE_SCANS > 1;
               end
            default:
               if (match)
                  state_d = PRESSED;
               else begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CNT_LAST) begin
                     state_d = IDLE;
                     held_d  = 1'b0;
                  end
               end
         endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sync1_q <= 4'b1111;
         sync2_q <= 4'b1111;
         div_q   <= '0;
         row_q   <= '0;
         snap_q  <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         cand_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         sync1_q <= kp.key_col;
         sync2_q <= sync1_q;
         div_q   <= div_d;
         row_q   <= row_d;
         snap_q  <= snap_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         held_q  <= held_d;
      end

   assign kp.key_row   = ~(4'b0001 << row_q);
   assign kp.key_code  = code_q;
   assign kp.key_valid = valid_q;
   assign kp.key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and random keypad scenarios checked against a scan-level debounce model.
module tb_keypad_scanner;
   localparam int DIV = 8;
   localparam int DB  = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] keys = '0;
   int          n_vec = 0;
   int          n_err = 0;

   bit          m_held, m_valid;
   logic [3:0]  m_code, m_cand;
   int          m_run;

   keypad_scanner_if kp ();
   keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_SCANS(DB)) dut (.clk(clk), .rst_n(rst_n), .kp(kp));

   always #5 clk = ~clk;

   // Physical matrix: a pressed key pulls its column low while its row is driven low.
   always_comb begin
      kp.key_col = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kp.key_row[r] && keys[r*4+c]) kp.key_col[c] = 1'b0;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_held = 0; m_valid = 0; m_code = '0; m_cand = '0; m_run = 0;
   endtask

   // Debounce as run lengths: a press needs DB consecutive identical single-key scans,
   // a release needs DB consecutive scans that do not show exactly the accepted key.
   task automatic model_scan(input logic [15:0] mask);
      bit         sgl;
      logic [3:0] k;
      sgl = $countones(mask) == 1;
      k = '0;
      for (int i = 0; i < 16; i++) if (mask[i]) k = 4'(i);
      m_valid = 0;
      if (!m_held) begin
         if (sgl && m_run > 0 && k == m_cand) m_run++;
         else if (sgl) begin m_cand = k; m_run = 1; end
         else m_run = 0;
         if (m_run == DB) begin m_code = m_cand; m_valid = 1; m_held = 1; m_run = 0; end
      end else begin
         if (sgl && k == m_code) m_run = 0;
         else m_run++;
         if (m_run == DB) begin m_held = 0; m_run = 0; end
      end
   endtask

   // One full scan starting at divider count 0 of row 0.
   task automatic scan(input logic [15:0] mask);
      logic [3:0] er;
      keys = mask;
      for (int i = 0; i < 4*DIV; i++) begin
         @(posedge clk); #1;
         er = 4'b1111 ^ (4'b0001 << (((i + 1) % (4*DIV)) / DIV));
         chk("key_row", kp.key_row, er);
         if (i == 4*DIV - 1) begin
            model_scan(mask);
            chk("key_valid_eval", kp.key_valid, m_valid);
            chk("key_held", kp.key_held, m_held);
            chk("key_code", kp.key_code, m_code);
         end else
            chk("key_valid_idle", kp.key_valid, 1'b0);
      end
   endtask

   task automatic scans(input logic [15:0] mask, input int n);
      for (int j = 0; j < n; j++) scan(mask);
   endtask

   initial begin
      logic [15:0] m;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_row", kp.key_row, 4'b1110);
      chk("rst_code", kp.key_code, 4'h0);
      chk("rst_valid", kp.key_valid, 1'b0);
      chk("rst_held", kp.key_held, 1'b0);
      rst_n = 1'b1;
      scans('0, 2);
      scans(16'h0040, 6);
      chk("press6_code", kp.key_code, 4'h6);
      chk("press6_held", kp.key_held, 1'b1);
      scans('0, 3);
      chk("rel6_held", kp.key_held, 1'b0);
      chk("rel6_code", kp.key_code, 4'h6);
      scans(16'h8000, 2);
      scan('0);
      scans(16'h8000, 2);
      chk("bounce_early", kp.key_held, 1'b0);
      scan(16'h8000);
      chk("bounce_code", kp.key_code, 4'hF);
      scans('0, 3);
      scans(16'h0021, 6);
      chk("multi_held", kp.key_held, 1'b0);
      scans(16'h0001, 3);
      chk("multi_code", kp.key_code, 4'h0);
      scans('0, 3);
      scans(16'h0008, 3);
      chk("chg_code3", kp.key_code, 4'h3);
      scans(16'h0200, 3);
      chk("chg_held_drop", kp.key_held, 1'b0);
      scans(16'h0200, 3);
      chk("chg_code9", kp.key_code, 4'h9);
      scans('0, 3);
      scans(16'h0040, 4);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_row", kp.key_row, 4'b1110);
      chk("midrst_code", kp.key_code, 4'h0);
      chk("midrst_held", kp.key_held, 1'b0);
      chk("midrst_valid", kp.key_valid, 1'b0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      scans(16'h0040, 4);
      chk("redeb_code", kp.key_code, 4'h6);
      m = '0;
      for (int s = 0; s < 80; s++) begin
         case ($urandom_range(0, 5))
            0: m = '0;
            1: m = 16'h0001 << $urandom_range(0, 15);
            2: m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            default: ;
         endcase
         scan(m);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad input scanner for a 4x4 key matrix. It is the input-side counterpart of the time-multiplexed seven-segment display scanner. It drives one keypad row low at a time and samples the four column lines. A full 4-row scan is debounced over several consecutive scans, and each debounced key press produces a single-cycle event carrying a 4-bit key code. It sits between the board keypad pins and the central FSM, which consumes `key_valid`/`key_code` for numeric entry.

## Interface
- `SCAN_DIV`, default 100000: clock cycles each row stays driven (1 ms at 100 MHz). Must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: number of consecutive agreeing full scans needed to accept a press or a release. Must be ≥ 1.
- `clk`  in  1: system clock, the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `key_col`  in  4: column lines, active low (pulled up on board), asynchronous to `clk`.
- `key_row`  out  4: row drive, active low. Exactly one bit is low at all times.
- `key_code`  out  4: code of the last accepted key, equal to row*4 + col.
- `key_valid`  out  1: one-cycle pulse when a press is accepted.
- `key_held`  out  1: high while the accepted key is considered held.

## Operation
- **Column synchronizer:** `key_col` passes through a 2-flop synchronizer before any use.
- **Row sequencer:**
  - Divider counts 0..SCAN_DIV-1 per row.
  - The row index advances 0→1→2→3→0 on divider terminal count.
  - `key_row` = ~(1 << row).
- **Sampling:** synchronized columns are sampled once per row, at divider count SCAN_DIV-1. This gives SCAN_DIV-1 cycles of settle time, which covers the synchronizer delay. The sample is stored in a 16-bit snapshot, bit row*4+col = ~col_sync[col].
- **Scan evaluation:** runs at the row-3 sample (end of scan). The scan result is one of:
  - SINGLE(code), when exactly one snapshot bit is set;
  - NONE, when zero bits are set, or two or more bits are set (ghosting and multi-press are rejected).
- **Debounce FSM:** states IDLE, DB_PRESS, PRESSED, DB_RELEASE. It is updated only on scan evaluation; `cnt` counts agreeing scans.
  - **IDLE:**
    - SINGLE(c): candidate=c, cnt=1, go to DB_PRESS. If DEBOUNCE_SCANS=1, go directly to PRESSED and accept.
    - NONE: stay in IDLE.
  - **DB_PRESS:**
    - SINGLE(candidate): cnt+1. When cnt reaches DEBOUNCE_SCANS, go to PRESSED and accept.
    - SINGLE(other): candidate=other, cnt=1.
    - NONE: go to IDLE.
  - **Accept:** `key_code` <= candidate, `key_valid` pulses, `key_held` <= 1.
  - **PRESSED:**
    - Result ≠ SINGLE(key_code): cnt=1, go to DB_RELEASE. If DEBOUNCE_SCANS=1, go directly to IDLE.
    - Otherwise stay in PRESSED.
  - **DB_RELEASE:**
    - Result ≠ SINGLE(key_code): cnt+1. When cnt reaches DEBOUNCE_SCANS, go to IDLE with `key_held` <= 0.
    - SINGLE(key_code): go back to PRESSED.
- **Key change without release:** switching directly from one key to another while PRESSED counts as a release first. The new key must then debounce from IDLE, so there is no `key_valid` for it until it has been stable for DEBOUNCE_SCANS scans after the release completes.
- **Hold:** `key_code` holds its value until the next accept. Releasing a key does not change it.

## Timing
- **Reset values (asynchronous):**
  - Divider = 0, row = 0, so `key_row` = 4'b1110.
  - Snapshot = 0, synchronizer flops = 4'b1111.
  - FSM in IDLE, cnt = 0.
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0.
- **Scan period:** 4*SCAN_DIV cycles.
- **Row switch:** `key_row` changes on the cycle after divider count SCAN_DIV-1.
- **Output update:** `key_valid` and `key_held` are registered. They change the cycle after the evaluating sample (row 3, count SCAN_DIV-1).
- **Press latency:** from a stable press of a key in row r, `key_valid` rises within DEBOUNCE_SCANS full scans plus at most one partial scan, plus 3 cycles (2 synchronizer + 1 output).
- **`key_valid` width:** exactly 1 cycle. It never asserts on two consecutive cycles.
- **Release:** `key_held` falls the cycle after the DEBOUNCE_SCANS-th non-matching evaluation.
- **Reset mid-operation:** all state returns to the reset values immediately. A key still held after reset deasserts must debounce again from IDLE and produces a fresh `key_valid`.

## Test plan
All scenarios use SCAN_DIV=8 and DEBOUNCE_SCANS=3, giving a scan of 32 cycles.
1. **Reset and row walk:** assert `rst_n`=0 → all outputs at reset values and `key_row`=1110. Release reset → `key_row` walks 1110, 1101, 1011, 0111, with each pattern lasting 8 cycles, then wraps.
2. **Single press:** model a key at row 1, col 2 (col2 low only while row1 is low) and hold it for 6 scans → exactly one `key_valid` pulse, `key_code`=6, `key_held`=1. Release → `key_held` drops after 3 empty scans, and `key_code` stays 6.
3. **Bounce:** press key 0xF for 2 scans, release for 1 scan, then press for 3 scans → exactly one `key_valid`, occurring after the final 3 scans.
4. **Multi-press:** press key 0 and key 5 together for 6 scans → no `key_valid` and `key_held`=0. Then release key 5 → after 3 scans, `key_valid` with `key_code`=0.
5. **Key change:** while key 3 is PRESSED, move directly to key 9 → `key_held` drops after 3 scans, then `key_valid` with `key_code`=9 follows 3 further scans later.
6. **Reset mid-press:** pulse `rst_n` low while key 6 is PRESSED, with the key still pressed → outputs clear immediately, then a new `key_valid` with `key_code`=6 appears after re-debounce.
